// File: rtl/flag_ctrl.sv
// Condition-code register {V,C,N,Z} with jump resolution, taken-jump flag clear
// and a LIFO shadow stack that saves/restores flags across nested interrupts.
module flag_ctrl #(
  parameter int CCR_WIDTH = 4,
  parameter int DEPTH     = 4,
  parameter int PTR_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 alu_flag_we,
  input  logic [CCR_WIDTH-1:0] alu_ccr,
  input  logic                 jmp_valid,
  input  logic [1:0]           jmp_cond,
  input  logic                 int_save,
  input  logic                 rti_restore,
  output logic [CCR_WIDTH-1:0] ccr,
  output logic                 jmp_taken,
  output logic [PTR_WIDTH-1:0] depth,
  output logic                 err_ovf,
  output logic                 err_udf,
  output logic                 err_col
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_WIDTH-1:0] FULL = PTR_WIDTH'(DEPTH);

  typedef logic [CCR_WIDTH-1:0] ccr_t;

  ccr_t [DEPTH-1:0] stk;
  ccr_t             nf;
  logic             tbit;
  logic [IW-1:0]    wr_idx, rd_idx;
  logic             full, empty;

  assign wr_idx = depth[IW-1:0];
  assign rd_idx = IW'(depth - PTR_WIDTH'(1));
  assign full   = (depth == FULL);
  assign empty  = (depth == '0);

  // Resolution uses the registered flags only; no bypass from alu_ccr.
  always_comb begin
    tbit = 1'b0;
    case (jmp_cond)
      2'b01:   tbit = ccr[0];
      2'b10:   tbit = ccr[1];
      2'b11:   tbit = ccr[2];
      default: tbit = 1'b0;
    endcase
    jmp_taken = jmp_valid & tbit;
  end

  always_comb begin
    nf = alu_flag_we ? alu_ccr : ccr;
    if (jmp_taken) begin
      case (jmp_cond)
        2'b01:   nf[0] = 1'b0;
        2'b10:   nf[1] = 1'b0;
        2'b11:   nf[2] = 1'b0;
        default: ;
      endcase
    end
  end

  // Stack contents need no reset; depth alone defines what is valid.
  always_ff @(posedge clk) begin
    if (!rst && !stall && int_save && !rti_restore && !full)
      stk[wr_idx] <= nf;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ccr     <= '0;
      depth   <= '0;
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
      err_col <= 1'b0;
    end else if (!stall) begin
      if (int_save && rti_restore) begin
        err_col <= 1'b1;
        ccr     <= nf;
      end else if (rti_restore) begin
        if (!empty) begin
          ccr   <= stk[rd_idx];
          depth <= depth - PTR_WIDTH'(1);
        end else begin
          err_udf <= 1'b1;
          ccr     <= nf;
        end
      end else if (int_save) begin
        if (!full) depth <= depth + PTR_WIDTH'(1);
        else       err_ovf <= 1'b1;
        ccr <= nf;
      end else begin
        ccr <= nf;
      end
    end
  end

endmodule
